// File: rtl/coin_validator.sv
// Coin-width classifier: times the synchronised sensor high pulse, classifies it
// into dime/nickel/quarter/reject windows and keeps a saturating credit total.
module coin_validator #(
   parameter int DIME_MIN    = 2,
   parameter int DIME_MAX    = 4,
   parameter int NICKEL_MIN  = 6,
   parameter int NICKEL_MAX  = 8,
   parameter int QUARTER_MIN = 10,
   parameter int QUARTER_MAX = 12,
   parameter int JAM_CYCLES  = 64,
   parameter int CREDIT_W    = 12,
   parameter int DIME_VAL    = 10,
   parameter int NICKEL_VAL  = 5,
   parameter int QUARTER_VAL = 25
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coinSensor,
   input  logic                credit_clr,
   output logic                dimeDetected,
   output logic                nickelDetected,
   output logic                quarterDetected,
   output logic                coinReject,
   output logic                jam,
   output logic [CREDIT_W-1:0] credit
);

   localparam int CW  = $clog2(JAM_CYCLES + 1);
   localparam int CVW = CREDIT_W + 1;

   localparam logic [CW-1:0] DMIN = CW'(DIME_MIN);
   localparam logic [CW-1:0] DMAX = CW'(DIME_MAX);
   localparam logic [CW-1:0] NMIN = CW'(NICKEL_MIN);
   localparam logic [CW-1:0] NMAX = CW'(NICKEL_MAX);
   localparam logic [CW-1:0] QMIN = CW'(QUARTER_MIN);
   localparam logic [CW-1:0] QMAX = CW'(QUARTER_MAX);
   localparam logic [CW-1:0] JAMC = CW'(JAM_CYCLES);

   localparam logic [CVW-1:0] DVAL = CVW'(DIME_VAL);
   localparam logic [CVW-1:0] NVAL = CVW'(NICKEL_VAL);
   localparam logic [CVW-1:0] QVAL = CVW'(QUARTER_VAL);

   if (!(DIME_MIN >= 1 && DIME_MIN <= DIME_MAX && DIME_MAX < NICKEL_MIN &&
         NICKEL_MIN <= NICKEL_MAX && NICKEL_MAX < QUARTER_MIN &&
         QUARTER_MIN <= QUARTER_MAX && QUARTER_MAX < JAM_CYCLES &&
         DIME_VAL < 2**CREDIT_W && NICKEL_VAL < 2**CREDIT_W &&
         QUARTER_VAL < 2**CREDIT_W)) begin : gParamCheck
      $error("coin_validator: windows must ascend, be disjoint and lie below JAM_CYCLES");
   end

   typedef enum logic [1:0] {WAIT_LOW, IDLE, MEASURE} state_t;

   state_t          state;
   logic            s1, s2;
   logic [1:0]      syncVld;
   logic [CW-1:0]   cnt;

   logic                isDime, isNickel, isQuarter, accept;
   logic [CVW-1:0]      addVal, sum;
   logic [CREDIT_W-1:0] base, nextCredit;

   // syncVld marks when s2 holds a genuine sample rather than its reset value,
   // so a coin still in the chute at reset release is not mistaken for a fall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         syncVld <= 2'b00;
      end else begin
         s1      <= coinSensor;
         s2      <= s1;
         syncVld <= {syncVld[0], 1'b1};
      end
   end

   always_comb begin
      isDime    = (cnt >= DMIN) && (cnt <= DMAX);
      isNickel  = (cnt >= NMIN) && (cnt <= NMAX);
      isQuarter = (cnt >= QMIN) && (cnt <= QMAX);
      accept    = isDime | isNickel | isQuarter;
      addVal    = '0;
      if (isDime)    addVal = DVAL;
      if (isNickel)  addVal = NVAL;
      if (isQuarter) addVal = QVAL;
      // clear applies before the add
      base       = credit_clr ? '0 : credit;
      sum        = {1'b0, base} + addVal;
      nextCredit = sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= WAIT_LOW;
         cnt             <= '0;
         dimeDetected    <= 1'b0;
         nickelDetected  <= 1'b0;
         quarterDetected <= 1'b0;
         coinReject      <= 1'b0;
         jam             <= 1'b0;
         credit          <= '0;
      end else begin
         dimeDetected    <= 1'b0;
         nickelDetected  <= 1'b0;
         quarterDetected <= 1'b0;
         coinReject      <= 1'b0;
         credit          <= base;
         case (state)
            WAIT_LOW: begin
               if (syncVld[1] && !s2) begin
                  state <= IDLE;
                  jam   <= 1'b0;
               end
            end
            IDLE: begin
               if (s2) begin
                  state <= MEASURE;
                  cnt   <= CW'(1);
               end else begin
                  cnt <= '0;
               end
            end
            MEASURE: begin
               if (s2) begin
                  if (cnt + 1'b1 == JAMC) begin
                     state <= WAIT_LOW;
                     jam   <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  state           <= IDLE;
                  dimeDetected    <= isDime;
                  nickelDetected  <= isNickel;
                  quarterDetected <= isQuarter;
                  coinReject      <= !accept;
                  if (accept) credit <= nextCredit;
               end
            end
            default: state <= WAIT_LOW;
         endcase
      end
   end

endmodule

// File: tb/tb_coin_validator.sv
// Directed bench for coin_validator: default instance plus a narrow-credit
// instance sharing the same inputs for the saturation case.
module tb_coin_validator;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic coinSensor = 1'b0;
   logic credit_clr = 1'b0;

   logic        dimeDetected, nickelDetected, quarterDetected, coinReject, jam;
   logic [11:0] credit;
   logic        sDime, sNickel, sQuarter, sReject, sJam;
   logic [5:0]  sCredit;

   int errCnt = 0;
   int chkCnt = 0;
   int pulseCnt = 0;

   always #5 clk = ~clk;

   coin_validator dut (
      .clk(clk), .reset(reset), .coinSensor(coinSensor), .credit_clr(credit_clr),
      .dimeDetected(dimeDetected), .nickelDetected(nickelDetected),
      .quarterDetected(quarterDetected), .coinReject(coinReject),
      .jam(jam), .credit(credit)
   );

   coin_validator #(.CREDIT_W(6)) dutS (
      .clk(clk), .reset(reset), .coinSensor(coinSensor), .credit_clr(credit_clr),
      .dimeDetected(sDime), .nickelDetected(sNickel),
      .quarterDetected(sQuarter), .coinReject(sReject),
      .jam(sJam), .credit(sCredit)
   );

   wire [3:0] pv = {dimeDetected, nickelDetected, quarterDetected, coinReject};

   always @(negedge clk) if (reset && pv != 4'b0000) pulseCnt++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chkCnt++;
      if (act !== exp) begin
         errCnt++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b0;
      coinSensor = 1'b0;
      credit_clr = 1'b0;
      tick(); tick();
      reset = 1'b1;
      repeat (4) tick();
   endtask

   // leaves the bench just after P2, the edge that registers the pulse
   task automatic sendCoin(input int w, input bit clrAtP2);
      coinSensor = 1'b1;
      repeat (w) tick();
      coinSensor = 1'b0;
      tick(); tick();
      credit_clr = clrAtP2;
      tick();
   endtask

   // {dime,nickel,quarter,reject} and running credit for widths 1..13
   logic [3:0] expPv [13] = '{4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0001,
                              4'b0100, 4'b0100, 4'b0100, 4'b0001,
                              4'b0010, 4'b0010, 4'b0010, 4'b0001};
   int expCr [13] = '{0, 10, 20, 30, 30, 35, 40, 45, 45, 70, 95, 120, 120};

   initial begin
      int snap;

      // 1: reset with sensor toggling
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         coinSensor = ~coinSensor;
         #5;
         chk("rst_outs", {27'd0, pv, jam}, 32'd0);
         chk("rst_credit", credit, 0);
      end
      coinSensor = 1'b0;
      reset = 1'b1;
      repeat (5) tick();
      chk("rst_nopulse", pulseCnt, 0);

      // 2: widths 1..13
      for (int w = 1; w <= 13; w++) begin
         coinSensor = 1'b1;
         repeat (w) tick();
         coinSensor = 1'b0;
         tick(); tick();
         chk($sformatf("w%0d_p1", w), pv, 4'b0000);
         tick();
         chk($sformatf("w%0d_pulse", w), pv, expPv[w-1]);
         chk($sformatf("w%0d_credit", w), credit, expCr[w-1]);
         tick();
         chk($sformatf("w%0d_p3", w), pv, 4'b0000);
      end
      chk("final_credit", credit, 120);
      chk("w_pulsecount", pulseCnt, 13);

      // 3: jam
      snap = pulseCnt;
      coinSensor = 1'b1;
      repeat (65) tick();
      chk("jam_before", jam, 0);
      tick();
      chk("jam_rise", jam, 1);
      repeat (4) tick();
      coinSensor = 1'b0;
      tick(); tick();
      chk("jam_p1", jam, 1);
      tick();
      chk("jam_clear", jam, 0);
      repeat (3) tick();
      chk("jam_nopulse", pulseCnt, snap);
      chk("jam_credit", credit, 120);

      // 4: saturation on the 6-bit instance
      doReset();
      sendCoin(11, 1'b0);
      chk("sat_q1", sCredit, 25);
      chk("sat_q1_pulse", sQuarter, 1);
      sendCoin(11, 1'b0);
      chk("sat_q2", sCredit, 50);
      sendCoin(11, 1'b0);
      chk("sat_q3", sCredit, 63);
      sendCoin(3, 1'b0);
      chk("sat_dime_pulse", sDime, 1);
      chk("sat_dime", sCredit, 63);

      // 5: clear coinciding with an accept, then clear alone
      doReset();
      sendCoin(11, 1'b0);
      sendCoin(6, 1'b0);
      sendCoin(3, 1'b0);
      chk("clr_pre", credit, 40);
      sendCoin(11, 1'b1);
      chk("clr_accept_pulse", quarterDetected, 1);
      chk("clr_accept", credit, 25);
      tick();
      chk("clr_alone", credit, 0);
      credit_clr = 1'b0;
      tick();

      // 6: reset in the middle of a coin
      doReset();
      snap = pulseCnt;
      coinSensor = 1'b1;
      repeat (5) tick();
      reset = 1'b0;
      #1;
      chk("midrst_outs", {27'd0, pv, jam}, 32'd0);
      tick(); tick();
      reset = 1'b1;
      repeat (4) tick();
      coinSensor = 1'b0;
      repeat (6) tick();
      chk("midrst_nopulse", pulseCnt, snap);
      sendCoin(3, 1'b0);
      chk("midrst_dime", pv, 4'b1000);
      chk("midrst_credit", credit, 10);
      tick();

      $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
      $finish;
   end

endmodule
